full_subtractor: RTL and testbench

Parameterizable ripple-borrow subtractor computing A − B − C, where C is the borrow-in. It is built from 1-bit full-subtractor cells. Outputs are registered by default on one clock and cleared by an asynchronous reset. It serves as a standalone arithmetic leaf block; the default WIDTH=1 gives the classic single-bit full subtractor.

---
 rtl/full_subtractor_cell.sv | 11 +
 rtl/full_subtractor.sv | 46 ++++
 tb/tb_full_subtractor.sv | 92 +++++++++
 3 files changed

// File: rtl/full_subtractor_cell.sv
// full_subtractor_cell: 1-bit borrow cell; a - b - bin gives difference d and borrow-out bout
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & (b | bin)) | (b & bin);
endmodule

// File: rtl/full_subtractor.sv
// full_subtractor: ripple-borrow D = A - B - C (mod 2^WIDTH) with borrow-out Borr_out, optionally registered on clk with async active-high rst
module full_subtractor #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  output logic [WIDTH-1:0] D,
  output logic             Borr_out
);
  logic [WIDTH:0]   bin;
  logic [WIDTH-1:0] d_d;
  logic             borr_d;
  assign bin[0] = C;
  assign borr_d = bin[WIDTH];
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_subtractor_cell u_cell (
      .a   (A[i]),
      .b   (B[i]),
      .bin (bin[i]),
      .d   (d_d[i]),
      .bout(bin[i+1])
    );
  end
  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] d_q;
    logic             borr_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        d_q    <= '0;
        borr_q <= 1'b0;
      end else begin
        d_q    <= d_d;
        borr_q <= borr_d;
      end
    end
    assign D        = d_q;
    assign Borr_out = borr_q;
  end else begin : g_comb
    assign D        = d_d;
    assign Borr_out = borr_d;
  end
endmodule

// File: tb/tb_full_subtractor.sv
// tb_full_subtractor: directed and reference-model checks of registered/combinational 1-bit and registered 4-bit subtractors
module tb_full_subtractor;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic       ac = 1'b0, bc = 1'b0, cc = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       c4 = 1'b0;
  logic       d1, bo1, dc, boc, bo4;
  logic [3:0] d4;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [1:0] tt [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
  always #5 clk = ~clk;
  full_subtractor #(.WIDTH(1), .REG_OUT(1'b1)) u_r1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .C(c1), .D(d1), .Borr_out(bo1));
  full_subtractor #(.WIDTH(1), .REG_OUT(1'b0)) u_c1 (
    .clk(clk), .rst(rst), .A(ac), .B(bc), .C(cc), .D(dc), .Borr_out(boc));
  full_subtractor #(.WIDTH(4), .REG_OUT(1'b1)) u_r4 (
    .clk(clk), .rst(rst), .A(a4), .B(b4), .C(c4), .D(d4), .Borr_out(bo4));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step4(input logic [3:0] a, input logic [3:0] b, input logic c,
                       input logic [3:0] exp_d, input logic exp_b, input string tag);
    {a4, b4, c4} = {a, b, c};
    @(posedge clk); #1;
    check({tag, "_d"}, 64'(d4), 64'(exp_d));
    check({tag, "_b"}, 64'(bo4), 64'(exp_b));
  endtask
  initial begin
    logic [2:0] v;
    logic [3:0] ra, rb;
    logic       rc;
    logic [4:0] r;
    repeat (2) @(posedge clk);
    #1;
    check("rst_d1", 64'(d1), 64'd0);
    check("rst_b1", 64'(bo1), 64'd0);
    check("rst_d4", 64'({bo4, d4}), 64'd0);
    rst = 1'b0;
    {a1, b1, c1} = 3'b001;
    @(posedge clk); #1;
    check("pre_async_d", 64'(d1), 64'd1);
    check("pre_async_b", 64'(bo1), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_d", 64'(d1), 64'd0);
    check("async_b", 64'(bo1), 64'd0);
    @(posedge clk); #1;
    check("hold_rst", 64'({bo1, d1}), 64'd0);
    rst = 1'b0;
    {a1, b1, c1} = 3'b100;
    @(posedge clk); #1;
    check("first_after_rst", 64'({d1, bo1}), 64'(2'b10));
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a1, b1, c1} = v;
      @(posedge clk); #1;
      check($sformatf("tt_reg_d_%0d", i), 64'(d1), 64'(tt[i][1]));
      check($sformatf("tt_reg_b_%0d", i), 64'(bo1), 64'(tt[i][0]));
    end
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {ac, bc, cc} = v;
      #1;
      check($sformatf("tt_comb_d_%0d", i), 64'(dc), 64'(tt[i][1]));
      check($sformatf("tt_comb_b_%0d", i), 64'(boc), 64'(tt[i][0]));
      #19;
    end
    @(posedge clk); #1;
    step4(4'd5, 4'd7, 1'b0, 4'd14, 1'b1, "wrap");
    step4(4'd9, 4'd3, 1'b1, 4'd5, 1'b0, "no_borrow");
    step4(4'd0, 4'd0, 1'b1, 4'd15, 1'b1, "zero_minus_c");
    step4(4'd15, 4'd15, 1'b0, 4'd0, 1'b0, "eq_ones");
    step4(4'd15, 4'd15, 1'b1, 4'd15, 1'b1, "ones_minus_c");
    step4(4'd6, 4'd6, 1'b0, 4'd0, 1'b0, "eq_mid");
    for (int i = 0; i < 1000; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      r  = {1'b0, ra} - {1'b0, rb} - {4'b0, rc};
      step4(ra, rb, rc, r[3:0], r[4], "rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
